// File: rtl/jk_multimode_reg_if.sv
// Bus bundle for jk_multimode_reg: control/data inputs and register outputs.
// When JK_MULTIMODE_REG_EDGE_EN is defined the bundle also carries the
// per-bit rise/fall pulse outputs.
interface jk_multimode_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             err;
    logic             chg;
    logic [CNT_W-1:0] chg_cnt;
`ifdef JK_MULTIMODE_REG_EDGE_EN
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (
        output en, mode, a, b, clr_err,
        input  q, qb, err, chg, chg_cnt, rise, fall
    );

    modport slave (
        input  en, mode, a, b, clr_err,
        output q, qb, err, chg, chg_cnt, rise, fall
    );
`else
    modport master (
        output en, mode, a, b, clr_err,
        input  q, qb, err, chg, chg_cnt
    );

    modport slave (
        input  en, mode, a, b, clr_err,
        output q, qb, err, chg, chg_cnt
    );
`endif
endinterface

// File: rtl/jk_multimode_reg.sv
// jk_multimode_reg: WIDTH-bit register with run-time JK/SR/D/T behaviour,
// clock enable, sticky illegal-SR error flag and a saturating change counter.
// Optional macro JK_MULTIMODE_REG_EDGE_EN adds registered per-bit rise/fall
// pulse outputs.
module jk_multimode_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input logic               clk,
    input logic               rst,
    jk_multimode_reg_if.slave bus
);
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] state_q, state_d;
    logic             err_q, err_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_n;
    logic             sr_illegal;

    // Per-bit next-state selection; each bit only looks at its own a/b/q.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic bit_n;

        // Next value of bit gi according to the active mode.
        always_comb begin
            bit_n = state_q[gi];
            unique case (bus.mode)
                MODE_JK: begin
                    unique case ({bus.a[gi], bus.b[gi]})
                        2'b00:   bit_n = state_q[gi];
                        2'b01:   bit_n = 1'b0;
                        2'b10:   bit_n = 1'b1;
                        default: bit_n = ~state_q[gi];
                    endcase
                end
                MODE_SR: begin
                    unique case ({bus.a[gi], bus.b[gi]})
                        2'b01:   bit_n = 1'b0;
                        2'b10:   bit_n = 1'b1;
                        // 00 holds, 11 is illegal and also holds
                        default: bit_n = state_q[gi];
                    endcase
                end
                MODE_D:  bit_n = bus.a[gi];
                default: bit_n = bus.a[gi] ? ~state_q[gi] : state_q[gi];
            endcase
        end

        assign q_n[gi] = bit_n;
    end

    assign sr_illegal = (bus.mode == MODE_SR) && ((bus.a & bus.b) != '0);

    // Next-state for register, error flag, change pulse and counter.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        chg_d   = 1'b0;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = RESET_VAL;
            err_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            if (bus.en) begin
                state_d = q_n;
                chg_d   = (q_n != state_q);
            end
            // A new illegal-SR event beats a simultaneous clear.
            if (bus.en && sr_illegal) begin
                err_d = 1'b1;
            end else if (bus.clr_err) begin
                err_d = 1'b0;
            end
            if (chg_d && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        err_q   <= err_d;
        chg_q   <= chg_d;
        cnt_q   <= cnt_d;
    end

    assign bus.q       = state_q;
    assign bus.qb      = ~state_q;
    assign bus.err     = err_q;
    assign bus.chg     = chg_q;
    assign bus.chg_cnt = cnt_q;

`ifdef JK_MULTIMODE_REG_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Edge pulses only for enabled updates; reset never produces a pulse.
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        if (!rst && bus.en) begin
            rise_d = q_n & ~state_q;
            fall_d = ~q_n & state_q;
        end
    end

    // Edge pulse registers.
    always_ff @(posedge clk) begin
        rise_q <= rise_d;
        fall_q <= fall_d;
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`endif

endmodule

// File: tb/tb_jk_multimode_reg.sv
// Directed testbench for jk_multimode_reg (WIDTH=4, CNT_W=2).
// A second instance with RESET_VAL=4'b1010 shares the same stimulus.
// Edge-pulse checks are active only when JK_MULTIMODE_REG_EDGE_EN is defined.
module tb_jk_multimode_reg;
    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;

    int vectors = 0;
    int fails   = 0;

    jk_multimode_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus0 ();
    jk_multimode_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus1 ();

    assign bus1.en      = bus0.en;
    assign bus1.mode    = bus0.mode;
    assign bus1.a       = bus0.a;
    assign bus1.b       = bus0.b;
    assign bus1.clr_err = bus0.clr_err;

    jk_multimode_reg #(.WIDTH(WIDTH), .RESET_VAL(4'b0000), .CNT_W(CNT_W)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    jk_multimode_reg #(.WIDTH(WIDTH), .RESET_VAL(4'b1010), .CNT_W(CNT_W)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [3:0] av, input logic [3:0] bv, input logic c);
        rst          = r;
        bus0.en      = e;
        bus0.mode    = m;
        bus0.a       = av;
        bus0.b       = bv;
        bus0.clr_err = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string name);
        $display("%s: q=%b chg=%b err=%b cnt=%0d", name, bus0.q, bus0.chg, bus0.err, bus0.chg_cnt);
    endtask

    initial begin
        // 1. Reset, two edges
        drive(1'b1, 1'b1, 2'b11, 4'hF, 4'h0, 1'b0);
        step();
        step();
        show("reset");
        check("rst_q",    32'(bus0.q), 32'h0);
        check("rst_qb",   32'(bus0.qb), 32'hF);
        check("rst_err",  32'(bus0.err), 32'h0);
        check("rst_chg",  32'(bus0.chg), 32'h0);
        check("rst_cnt",  32'(bus0.chg_cnt), 32'h0);
        check("rst_q_rv", 32'(bus1.q), 32'hA);
        check("rst_qb_rv", 32'(bus1.qb), 32'h5);

        // 2. JK truth table
        drive(1'b0, 1'b1, 2'b00, 4'b0011, 4'b0101, 1'b0);
        step();
        show("jk1");
        check("jk1_q",   32'(bus0.q), 32'b0011);
        check("jk1_chg", 32'(bus0.chg), 32'h1);
        check("jk1_cnt", 32'(bus0.chg_cnt), 32'h1);
        check("jk1_q_rv", 32'(bus1.q), 32'b1011);
        step();
        show("jk2");
        check("jk2_q",   32'(bus0.q), 32'b0010);
        check("jk2_chg", 32'(bus0.chg), 32'h1);
        check("jk2_cnt", 32'(bus0.chg_cnt), 32'h2);

        // 3. SR illegal combination and sticky error
        drive(1'b0, 1'b1, 2'b01, 4'b0110, 4'b0100, 1'b0);
        step();
        show("sr_ill");
        check("sr_q",   32'(bus0.q), 32'b0010);
        check("sr_err", 32'(bus0.err), 32'h1);
        check("sr_chg", 32'(bus0.chg), 32'h0);
        check("sr_cnt", 32'(bus0.chg_cnt), 32'h2);
        drive(1'b0, 1'b1, 2'b01, 4'b0100, 4'b0100, 1'b1);
        step();
        show("sr_setclr");
        check("sr_setwins", 32'(bus0.err), 32'h1);
        drive(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 1'b1);
        step();
        show("sr_clr");
        check("sr_clr_err", 32'(bus0.err), 32'h0);
        check("sr_clr_q",   32'(bus0.q), 32'b0010);
        // SR reset of bit1
        drive(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0010, 1'b0);
        step();
        show("sr_r");
        check("sr_r_q",   32'(bus0.q), 32'b0000);
        check("sr_r_cnt", 32'(bus0.chg_cnt), 32'h3);

        // 4. T mode with counter saturation, from reset
        drive(1'b1, 1'b1, 2'b11, 4'b0001, 4'b0000, 1'b0);
        step();
        check("t_rst_cnt", 32'(bus0.chg_cnt), 32'h0);
        drive(1'b0, 1'b1, 2'b11, 4'b0001, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            show($sformatf("t%0d", i));
            check($sformatf("t%0d_q", i),   32'(bus0.q), (i % 2 == 0) ? 32'b0001 : 32'b0000);
            check($sformatf("t%0d_chg", i), 32'(bus0.chg), 32'h1);
            check($sformatf("t%0d_cnt", i), 32'(bus0.chg_cnt), (i < 3) ? 32'(i + 1) : 32'h3);
        end

        // 5. Enable, clear while disabled, reset mid-operation
        drive(1'b0, 1'b1, 2'b01, 4'b1000, 4'b1000, 1'b0);
        step();
        show("set_err");
        check("en_seterr", 32'(bus0.err), 32'h1);
        check("en_seterr_q", 32'(bus0.q), 32'b0001);
        drive(1'b0, 1'b0, 2'b10, 4'b1111, 4'b0000, 1'b1);
        step();
        show("en0_clr");
        check("en0_q",   32'(bus0.q), 32'b0001);
        check("en0_chg", 32'(bus0.chg), 32'h0);
        check("en0_cnt", 32'(bus0.chg_cnt), 32'h3);
        check("en0_err", 32'(bus0.err), 32'h0);
        drive(1'b0, 1'b0, 2'b01, 4'b1111, 4'b1111, 1'b0);
        step();
        show("en0_sr");
        check("en0_sr_err", 32'(bus0.err), 32'h0);
        drive(1'b1, 1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0);
        step();
        show("mid_rst");
        check("mid_rst_q",   32'(bus0.q), 32'h0);
        check("mid_rst_cnt", 32'(bus0.chg_cnt), 32'h0);
        check("mid_rst_chg", 32'(bus0.chg), 32'h0);

        // 6. D mode and edge pulses
        drive(1'b0, 1'b1, 2'b10, 4'b0101, 4'b0000, 1'b0);
        step();
        show("d1");
        check("d1_q", 32'(bus0.q), 32'b0101);
`ifdef JK_MULTIMODE_REG_EDGE_EN
        check("d1_rise", 32'(bus0.rise), 32'b0101);
        check("d1_fall", 32'(bus0.fall), 32'b0000);
`endif
        drive(1'b0, 1'b1, 2'b10, 4'b0011, 4'b0000, 1'b0);
        step();
        show("d2");
        check("d2_q", 32'(bus0.q), 32'b0011);
        check("d2_cnt", 32'(bus0.chg_cnt), 32'h2);
`ifdef JK_MULTIMODE_REG_EDGE_EN
        check("d2_rise", 32'(bus0.rise), 32'b0010);
        check("d2_fall", 32'(bus0.fall), 32'b0100);
`endif
        drive(1'b0, 1'b0, 2'b10, 4'b1100, 4'b0000, 1'b0);
        step();
        show("d_en0");
        check("d_en0_q", 32'(bus0.q), 32'b0011);
`ifdef JK_MULTIMODE_REG_EDGE_EN
        check("d_en0_rise", 32'(bus0.rise), 32'b0000);
        check("d_en0_fall", 32'(bus0.fall), 32'b0000);
`endif
        drive(1'b1, 1'b1, 2'b10, 4'b1100, 4'b0000, 1'b0);
        step();
        show("d_rst");
        check("d_rst_q", 32'(bus0.q), 32'b0000);
`ifdef JK_MULTIMODE_REG_EDGE_EN
        check("d_rst_rise", 32'(bus0.rise), 32'b0000);
        check("d_rst_fall", 32'(bus0.fall), 32'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
